// File: rtl/tlb.sv
// Fully associative joint TLB sitting next to CP0.
// Two combinational search ports (s0 fetch, s1 data/TLBP), one combinational
// read port (TLBR) and one clocked write port (TLBWI).
// Optional feature macro: TLB_RANDOM_EN adds a free-running Random counter,
// the tlbwr input and the random_index output so TLBWR can target it.
module tlb #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    // search port 0: instruction fetch
    input  logic [18:0]     s0_vpn2,
    input  logic            s0_odd_page,
    input  logic [7:0]      s0_asid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_pfn,
    output logic [2:0]      s0_c,
    output logic            s0_d,
    output logic            s0_v,
    // search port 1: data access and TLBP
    input  logic [18:0]     s1_vpn2,
    input  logic            s1_odd_page,
    input  logic [7:0]      s1_asid,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_pfn,
    output logic [2:0]      s1_c,
    output logic            s1_d,
    output logic            s1_v,
    // write port: TLBWI (and TLBWR when the Random counter is present)
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic [18:0]     w_vpn2,
    input  logic [7:0]      w_asid,
    input  logic            w_g,
    input  logic [19:0]     w_pfn0,
    input  logic [2:0]      w_c0,
    input  logic            w_d0,
    input  logic            w_v0,
    input  logic [19:0]     w_pfn1,
    input  logic [2:0]      w_c1,
    input  logic            w_d1,
    input  logic            w_v1,
`ifdef TLB_RANDOM_EN
    input  logic            tlbwr,
    output logic [IDXW-1:0] random_index,
`endif
    // read port: TLBR
    input  logic [IDXW-1:0] r_index,
    output logic [18:0]     r_vpn2,
    output logic [7:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_pfn0,
    output logic [2:0]      r_c0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_pfn1,
    output logic [2:0]      r_c1,
    output logic            r_d1,
    output logic            r_v1
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] index;
        logic [19:0]     pfn;
        logic [2:0]      c;
        logic            d;
        logic            v;
    } hit_t;

    entry_t          entry_q [TLBNUM];
    entry_t          entry_d [TLBNUM];
    entry_t          w_entry;
    entry_t          r_entry;
    logic [IDXW-1:0] wr_idx;

    logic [18:0]     srch_vpn2 [2];
    logic            srch_odd  [2];
    logic [7:0]      srch_asid [2];
    hit_t            hit       [2];

    assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                       pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

`ifdef TLB_RANDOM_EN
    logic [IDXW-1:0] rand_q;
    logic [IDXW-1:0] rand_d;

    // Random counts down every cycle, wrapping from 0 back to the top entry
    always_comb begin
        rand_d = (rand_q == '0) ? IDXW'(TLBNUM - 1) : rand_q - IDXW'(1);
    end

    // Random register; keeps running through writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rand_q <= IDXW'(TLBNUM - 1);
        else         rand_q <= rand_d;
    end

    assign random_index = rand_q;
    assign wr_idx       = tlbwr ? rand_q : w_index;
`else
    assign wr_idx = w_index;
`endif

    // Next entry contents: only the addressed entry changes; an index past
    // the last entry matches nothing, so such a write is dropped
    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            entry_d[i] = entry_q[i];
            if (we && (int'(wr_idx) == i)) entry_d[i] = w_entry;
        end
    end

    // Entry storage; reset clears every field and overrides a pending write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < TLBNUM; i++) entry_q[i] <= entry_d[i];
        end
    end

    assign srch_vpn2[0] = s0_vpn2;
    assign srch_odd[0]  = s0_odd_page;
    assign srch_asid[0] = s0_asid;
    assign srch_vpn2[1] = s1_vpn2;
    assign srch_odd[1]  = s1_odd_page;
    assign srch_asid[1] = s1_asid;

    // Associative search; scanning from the top down lets the lowest
    // matching index overwrite any higher one. V does not gate the match.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p] = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if ((entry_q[i].vpn2 == srch_vpn2[p]) &&
                    (entry_q[i].g || (entry_q[i].asid == srch_asid[p]))) begin
                    hit[p].found = 1'b1;
                    hit[p].index = IDXW'(i);
                    hit[p].pfn   = srch_odd[p] ? entry_q[i].pfn1 : entry_q[i].pfn0;
                    hit[p].c     = srch_odd[p] ? entry_q[i].c1   : entry_q[i].c0;
                    hit[p].d     = srch_odd[p] ? entry_q[i].d1   : entry_q[i].d0;
                    hit[p].v     = srch_odd[p] ? entry_q[i].v1   : entry_q[i].v0;
                end
            end
        end
    end

    // Read port; an index past the last entry reads as all zeros
    always_comb begin
        r_entry = '0;
        if (int'(r_index) < TLBNUM) r_entry = entry_q[r_index];
    end

    assign s0_found = hit[0].found;
    assign s0_index = hit[0].index;
    assign s0_pfn   = hit[0].pfn;
    assign s0_c     = hit[0].c;
    assign s0_d     = hit[0].d;
    assign s0_v     = hit[0].v;

    assign s1_found = hit[1].found;
    assign s1_index = hit[1].index;
    assign s1_pfn   = hit[1].pfn;
    assign s1_c     = hit[1].c;
    assign s1_d     = hit[1].d;
    assign s1_v     = hit[1].v;

    assign r_vpn2 = r_entry.vpn2;
    assign r_asid = r_entry.asid;
    assign r_g    = r_entry.g;
    assign r_pfn0 = r_entry.pfn0;
    assign r_c0   = r_entry.c0;
    assign r_d0   = r_entry.d0;
    assign r_v0   = r_entry.v0;
    assign r_pfn1 = r_entry.pfn1;
    assign r_c1   = r_entry.c1;
    assign r_d1   = r_entry.d1;
    assign r_v1   = r_entry.v1;

endmodule

// File: tb/tb_tlb.sv
// Testbench for tlb: directed scenarios followed by randomized traffic.
// Expected search/read results come from a page-indexed reference table.
module tb_tlb;

    localparam int N  = 16;
    localparam int IW = 4;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUT signals
    logic [18:0]   s0_vpn2, s1_vpn2;
    logic          s0_odd_page, s1_odd_page;
    logic [7:0]    s0_asid, s1_asid;
    logic          s0_found, s1_found;
    logic [IW-1:0] s0_index, s1_index;
    logic [19:0]   s0_pfn, s1_pfn;
    logic [2:0]    s0_c, s1_c;
    logic          s0_d, s1_d, s0_v, s1_v;
    logic          we;
    logic [IW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0, w_pfn1;
    logic [2:0]    w_c0, w_c1;
    logic          w_d0, w_v0, w_d1, w_v1;
    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0, r_pfn1;
    logic [2:0]    r_c0, r_c1;
    logic          r_d0, r_v0, r_d1, r_v1;
`ifdef TLB_RANDOM_EN
    logic          tlbwr;
    logic [IW-1:0] random_index;
    logic [IW-1:0] m_rand;
`endif

    tlb #(.TLBNUM(N)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
`ifdef TLB_RANDOM_EN
        .tlbwr(tlbwr), .random_index(random_index),
`endif
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    // ------------------------------------------------------------ reference model
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic        m_g    [N];
    logic [19:0] m_pfn  [N][2];
    logic [2:0]  m_c    [N][2];
    logic        m_d    [N][2];
    logic        m_v    [N][2];

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_pfn[i][p] = '0; m_c[i][p] = '0; m_d[i][p] = 1'b0; m_v[i][p] = 1'b0;
            end
        end
    endtask

    task automatic model_write(input int idx);
        if (idx < N) begin
            m_vpn2[idx] = w_vpn2; m_asid[idx] = w_asid; m_g[idx] = w_g;
            m_pfn[idx][0] = w_pfn0; m_c[idx][0] = w_c0; m_d[idx][0] = w_d0; m_v[idx][0] = w_v0;
            m_pfn[idx][1] = w_pfn1; m_c[idx][1] = w_c1; m_d[idx][1] = w_d1; m_v[idx][1] = w_v1;
        end
    endtask

    // first matching entry in ascending order; all zero when nothing matches
    function automatic logic [29:0] model_search(input logic [18:0] vpn2, input logic odd,
                                                 input logic [7:0] asid);
        logic [29:0] res;
        logic        got;
        int          pg;
        res = '0;
        got = 1'b0;
        pg  = odd ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            if (!got && m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) begin
                got = 1'b1;
                res = {1'b1, IW'(i), m_pfn[i][pg], m_c[i][pg], m_d[i][pg], m_v[i][pg]};
            end
        end
        return res;
    endfunction

    function automatic logic [77:0] model_read(input logic [IW-1:0] idx);
        return {m_vpn2[idx], m_asid[idx], m_g[idx],
                m_pfn[idx][0], m_c[idx][0], m_d[idx][0], m_v[idx][0],
                m_pfn[idx][1], m_c[idx][1], m_d[idx][1], m_v[idx][1]};
    endfunction

    // ------------------------------------------------------------ scoreboard
    logic [95:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        chk_en = 1'b0;

    task automatic pop_check(input string name, input logic [95:0] act);
        logic [95:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected entry queued, got %h", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL %s @%0t: got %h expected %h", name, $time, act, e);
            end
        end
    endtask

    // monitor: compare every port in a fixed order once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            pop_check("s0", {2'd0, 64'd0, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v});
            pop_check("s1", {2'd1, 64'd0, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v});
            pop_check("rd", {2'd2, 16'd0, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                             r_pfn1, r_c1, r_d1, r_v1});
`ifdef TLB_RANDOM_EN
            pop_check("rand", {2'd3, 90'd0, random_index});
`endif
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic wr(input int idx, input logic [18:0] vpn2, input logic [7:0] asid,
                      input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                      input logic d0, input logic v0, input logic [19:0] pfn1,
                      input logic [2:0] c1, input logic d1, input logic v1);
        we = 1'b1; w_index = IW'(idx); w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic srch0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
    endtask

    task automatic srch1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
    endtask

    task automatic rd(input int idx);
        r_index = IW'(idx);
    endtask

    // queue this cycle's expectations (pre-write contents), then commit the
    // model update that the coming clock edge performs
    task automatic tick();
        int tgt;
        if (!resetn) model_clear();
        exp_q.push_back({2'd0, 64'd0, model_search(s0_vpn2, s0_odd_page, s0_asid)});
        exp_q.push_back({2'd1, 64'd0, model_search(s1_vpn2, s1_odd_page, s1_asid)});
        exp_q.push_back({2'd2, 16'd0, model_read(r_index)});
        tgt = int'(w_index);
`ifdef TLB_RANDOM_EN
        if (!resetn) m_rand = IW'(N - 1);
        exp_q.push_back({2'd3, 90'd0, m_rand});
        if (tlbwr) tgt = int'(m_rand);
        if (resetn) m_rand = (m_rand == 0) ? IW'(N - 1) : m_rand - IW'(1);
`endif
        if (resetn && we) model_write(tgt);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
`ifdef TLB_RANDOM_EN
        tlbwr = 1'b0;
`endif
    endtask

    function automatic logic [18:0] pick_vpn2();
        case ($urandom_range(0, 3))
            0:       return 19'h00040;
            1:       return 19'h7FFFF;
            2:       return 19'h01234;
            default: return 19'($urandom_range(0, 7));
        endcase
    endfunction

    // ------------------------------------------------------------ stimulus
    initial begin
        model_clear();
        resetn = 1'b0;
        we = 1'b0;
        wr(0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        we = 1'b0;
`ifdef TLB_RANDOM_EN
        tlbwr  = 1'b0;
        m_rand = IW'(N - 1);
`endif
        srch0(19'h0, 1'b0, 8'h00);
        srch1(19'h12345, 1'b0, 8'h01);
        rd(5);
        @(posedge clk);
        #1;

        // reset: zero search hits entry 0, other searches miss, reads are zero;
        // a write attempted under reset must not land
        tick();
        wr(1, 19'h00055, 8'h01, 1'b1, 20'hABCDE, 3'd2, 1'b1, 1'b1, 20'h12121, 3'd1, 1'b1, 1'b1);
        tick();
        resetn = 1'b1;
        srch0(19'h12345, 1'b0, 8'h01);
        srch1(19'h00055, 1'b0, 8'h01);
        rd(1);
        tick();

        // write entry 3; same-cycle search still sees old contents
        wr(3, 19'h00040, 8'h05, 1'b0, 20'h11111, 3'd0, 1'b0, 1'b1, 20'h22222, 3'd3, 1'b1, 1'b1);
        srch1(19'h00040, 1'b1, 8'h05);
        rd(3);
        tick();
        srch1(19'h00040, 1'b1, 8'h05);
        srch0(19'h00040, 1'b1, 8'h06);
        tick();
        srch0(19'h00040, 1'b0, 8'h05);
        tick();

        // rewrite entry 3 as global; read in the write cycle returns g=0
        wr(3, 19'h00040, 8'h05, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b1, 20'h22222, 3'd3, 1'b1, 1'b1);
        rd(3);
        tick();
        srch0(19'h00040, 1'b0, 8'hAA);
        tick();

        // duplicate global entries 2 and 9: lowest index wins
        wr(2, 19'h7FFFF, 8'h01, 1'b1, 20'hA0002, 3'd2, 1'b0, 1'b1, 20'hB0002, 3'd5, 1'b1, 1'b0);
        tick();
        wr(9, 19'h7FFFF, 8'h02, 1'b1, 20'hA0009, 3'd7, 1'b1, 1'b1, 20'hB0009, 3'd6, 1'b0, 1'b1);
        tick();
        srch1(19'h7FFFF, 1'b1, 8'h00);
        srch0(19'h7FFFF, 1'b0, 8'h33);
        rd(9);
        tick();

        // invalid even page still reports found with v=0; s0/s1 on different entries
        wr(7, 19'h01234, 8'h10, 1'b0, 20'h77777, 3'd1, 1'b1, 1'b0, 20'h78787, 3'd4, 1'b0, 1'b1);
        tick();
        srch0(19'h01234, 1'b0, 8'h10);
        srch1(19'h00040, 1'b1, 8'h33);
        rd(7);
        tick();

        // reset in the same cycle as a write: everything cleared, write lost
        resetn = 1'b0;
        wr(4, 19'h00444, 8'h04, 1'b1, 20'h44444, 3'd4, 1'b1, 1'b1, 20'h45454, 3'd4, 1'b1, 1'b1);
        srch0(19'h00040, 1'b0, 8'hAA);
        tick();
        resetn = 1'b1;
        srch0(19'h00444, 1'b0, 8'h04);
        srch1(19'h00040, 1'b1, 8'h05);
        rd(4);
        tick();

        // randomized traffic over a small vpn2/asid pool to force hits and aliases
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                wr($urandom_range(0, N - 1), pick_vpn2(), 8'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 20'($urandom), 3'($urandom), 1'($urandom),
                   1'($urandom), 20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
`ifdef TLB_RANDOM_EN
                tlbwr = 1'($urandom_range(0, 1));
`endif
            end
`ifdef TLB_RANDOM_EN
            else if ($urandom_range(0, 3) == 0) begin
                tlbwr = 1'b1;
            end
`endif
            srch0(pick_vpn2(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
            srch1(pick_vpn2(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
            rd($urandom_range(0, N - 1));
            tick();
        end

        // ------------------------------------------------------------ report
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
